uart8_transmitter: RTL



---
 rtl/uart8_transmitter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart8_transmitter.sv
// uart8_transmitter: 8-bit UART TX, 1 start, 8 data LSB-first, STOP_BITS stop.
// 16x oversampled clock; one-entry holding register for gap-free frames.
module uart8_transmitter #(
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       start,
   input  logic [7:0] in,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       out
);

   typedef enum logic [2:0] {
      S_RESET,
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   localparam logic LAST_STOP = 1'(STOP_BITS - 1);

   state_t     r_state;
   logic [7:0] r_shift;
   logic [7:0] r_hold;
   logic       r_hold_valid;
   logic [3:0] r_tick;
   logic [2:0] r_bit;
   logic       r_stop;
   logic       r_out;
   logic       r_busy;
   logic       r_done;

   logic       w_accept;
   logic       w_tick_end;
   logic       w_frame_end;

   // handshake and frame-boundary decode
   always_comb begin
      ready       = en && (r_state != S_RESET) && !r_hold_valid;
      w_accept    = start && ready;
      w_tick_end  = (r_tick == 4'd15);
      w_frame_end = (r_state == S_STOP) && w_tick_end
                    && (r_stop == LAST_STOP);
   end

   assign busy = r_busy;
   assign done = r_done;
   assign out  = r_out;

   // frame sequencer: bit timing, shifting, holding register, abort
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_RESET;
         r_shift      <= '0;
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
         r_tick       <= '0;
         r_bit        <= '0;
         r_stop       <= 1'b0;
         r_out        <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else if (!en) begin
         r_state      <= S_RESET;
         r_shift      <= '0;
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
         r_tick       <= '0;
         r_bit        <= '0;
         r_stop       <= 1'b0;
         r_out        <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept && (r_state != S_IDLE) && !w_frame_end) begin
            r_hold       <= in;
            r_hold_valid <= 1'b1;
         end
         unique case (r_state)
            S_RESET: begin
               r_state <= S_IDLE;
            end
            S_IDLE: begin
               r_out  <= 1'b1;
               r_busy <= 1'b0;
               r_tick <= '0;
               if (w_accept) begin
                  r_shift <= in;
                  r_out   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_START;
               end
            end
            S_START: begin
               r_tick <= r_tick + 4'd1;
               if (w_tick_end) begin
                  r_out   <= r_shift[0];
                  r_bit   <= '0;
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               r_tick <= r_tick + 4'd1;
               if (w_tick_end) begin
                  r_shift <= r_shift >> 1;
                  if (r_bit == 3'd7) begin
                     r_bit   <= '0;
                     r_stop  <= 1'b0;
                     r_out   <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_bit <= r_bit + 3'd1;
                     r_out <= r_shift[1];
                  end
               end
            end
            S_STOP: begin
               r_tick <= r_tick + 4'd1;
               r_out  <= 1'b1;
               if ((r_tick == 4'd14) && (r_stop == LAST_STOP)) begin
                  r_done <= 1'b1;
               end
               if (w_frame_end) begin
                  r_stop <= 1'b0;
                  if (r_hold_valid) begin
                     r_shift      <= r_hold;
                     r_hold_valid <= 1'b0;
                     r_out        <= 1'b0;
                     r_state      <= S_START;
                  end else if (w_accept) begin
                     r_shift <= in;
                     r_out   <= 1'b0;
                     r_state <= S_START;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end else if (w_tick_end) begin
                  r_stop <= r_stop + 1'b1;
               end
            end
            default: begin
               r_state      <= S_RESET;
               r_hold_valid <= 1'b0;
               r_out        <= 1'b1;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
